dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single data-memory port between the RISC-V core datapath and an external burst requester (program loader / debug DMA).
- The core keeps zero-latency access when the port is free. While an external burst owns the port, the core is stalled via core_stall, which holds PC and suppresses reg_wr/mem_wr in the datapath.
- A starvation limiter forces a one-cycle core slot during long bursts.

Parameters:
- LEN_W, 8, width of ext_len; a burst is ext_len+1 words (1..2^LEN_W).
- STARVE_LIMIT, 4, maximum consecutive stalled core_req cycles before a forced core slot (legal range 1..255).

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- core_req  in  1  core issues a load/store this cycle
- core_wr  in  1  core store
- core_addr  in  32  core byte address (ALU result)
- core_wdata  in  32  core store data
- core_mask  in  4  core byte-enable mask
- core_load_ctrl  in  3  core load format (funct3 encoding)
- core_rdata  out  32  load data to core writeback mux
- core_stall  out  1  core must hold PC and suppress writes
- ext_req  in  1  external burst command strobe
- ext_wr  in  1  1 = write burst, 0 = read burst
- ext_base  in  32  burst start byte address; bits [1:0] ignored
- ext_len  in  LEN_W  beats minus one
- ext_wdata  in  32  write data for the current beat
- ext_beat_valid  in  1  external side offers or accepts a beat
- ext_beat_ready  out  1  arbiter grants a beat this cycle
- ext_rdata  out  32  read data; valid when valid&ready&!wr
- ext_busy  out  1  burst latched and not yet finished
- ext_done  out  1  one-cycle pulse after the last beat
- mem_wr  out  1  to data memory
- mem_addr  out  32
- mem_wdata  out  32
- mem_mask  out  4
- mem_load_ctrl  out  3
- mem_rdata  in  32  combinational read data from data memory

Behaviour:
- Reset (asynchronous): state=IDLE, beat_cnt=0, wait_cnt=0, ext_busy=0, ext_done=0, latched command cleared.
- Reset values of outputs: core_stall=0 and ext_beat_ready=0; mem_* follow the core inputs (IDLE mux).
- States: IDLE, BURST, YIELD.
- IDLE:
  - Port muxed combinationally from core_*; core_stall=0; ext_beat_ready=0.
  - mem_wr = core_req & core_wr.
  - ext_req=1 latches wr/base/len; next state=BURST; ext_busy=1 from the next cycle.
  - Simultaneous core_req and ext_req: the core is served this cycle and the command is still latched.
- BURST:
  - mem_addr = {base[31:2],2'b00} + 4*beat_cnt, 32-bit modulo (wraps past 0xFFFFFFFC).
  - mem_mask=4'b1111; mem_load_ctrl=3'b010 (LW); mem_wdata=ext_wdata; mem_wr = wr & ext_beat_valid.
  - ext_beat_ready=1, except in the cycle where the YIELD transition is decided.
  - core_stall = core_req.
  - Beat fires on valid&ready; beat_cnt increments.
  - Last beat (beat_cnt==len fires): next state=IDLE; ext_done=1 next cycle for exactly one cycle; ext_busy=0 next cycle.
- Starvation:
  - In BURST, wait_cnt increments each cycle core_req=1; it clears when core_req=0.
  - When wait_cnt==STARVE_LIMIT-1 and core_req=1, that cycle has ext_beat_ready=0 and the next state is YIELD.
- YIELD:
  - Exactly one cycle; port muxed from core; core_stall=0; ext_beat_ready=0.
  - wait_cnt cleared; next state=BURST.
  - beat_cnt is unchanged.
- core_rdata = mem_rdata in all states; it is meaningful only when core_stall=0.
- ext_req while ext_busy=1 or ext_done=1 is ignored; no queueing.
- ext_beat_valid=0 in BURST stalls the burst with no timeout; the core remains stalled subject only to STARVE_LIMIT.
- Reset mid-burst aborts immediately: no ext_done pulse; partially written words remain in memory.

Optional Feature:
- Macro ARB_PERF_EN.
- Defined:
  - Ports perf_stall_cnt (out 32) and perf_yield_cnt (out 32) exist.
  - perf_stall_cnt counts cycles with core_stall=1; perf_yield_cnt counts YIELD entries.
  - Both saturate at 0xFFFFFFFF and clear on rst.
- Undefined: both ports are still present, tied to 0; no counter logic is synthesized.

Test Plan:
- Core store in IDLE: core_req=1, core_wr=1, addr=0x10, wdata=0xDEADBEEF, mask=4'b1111 -> same cycle mem_wr=1, mem_addr=0x10, core_stall=0.
- Write burst: base=0x100, len=3, valid held 1, core idle -> mem_addr 0x100,0x104,0x108,0x10C on four consecutive cycles; ext_done pulses the cycle after 0x10C; ext_busy=0.
- Read burst with core_req=1 throughout, STARVE_LIMIT=4, len=9 -> three beats, one non-ready cycle, one YIELD cycle with core_stall=0, then beats resume at beat 3; the pattern repeats until done.
- Same-cycle ext_req and core load in IDLE -> the core load completes (core_stall=0); BURST starts the next cycle.
- Wrap and reset: base=0xFFFFFFFC, len=1 -> addresses 0xFFFFFFFC then 0x00000000. Assert rst between the beats in a repeat run -> immediate IDLE, ext_busy=0, no ext_done.
- With ARB_PERF_EN: run the scenario-3 traffic -> perf_yield_cnt equals the YIELD count and perf_stall_cnt equals the stalled cycles. Without ARB_PERF_EN: both read 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Purpose: shares the data-memory port between the core datapath and an external burst requester.
// Latency: core access is combinational in IDLE/YIELD; burst beats address memory in the cycle they fire.
// Backpressure: ext_beat_ready drops for one cycle per starvation yield; core_stall holds the core while a burst owns the port.
// Optional: define ARB_PERF_EN to build the stall/yield performance counters (ports tie to 0 otherwise).
module dmem_arbiter #(
    parameter int LEN_W        = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             core_req,
    input  logic             core_wr,
    input  logic [31:0]      core_addr,
    input  logic [31:0]      core_wdata,
    input  logic [3:0]       core_mask,
    input  logic [2:0]       core_load_ctrl,
    output logic [31:0]      core_rdata,
    output logic             core_stall,
    input  logic             ext_req,
    input  logic             ext_wr,
    input  logic [31:0]      ext_base,
    input  logic [LEN_W-1:0] ext_len,
    input  logic [31:0]      ext_wdata,
    input  logic             ext_beat_valid,
    output logic             ext_beat_ready,
    output logic [31:0]      ext_rdata,
    output logic             ext_busy,
    output logic             ext_done,
    output logic             mem_wr,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_mask,
    output logic [2:0]       mem_load_ctrl,
    input  logic [31:0]      mem_rdata,
    output logic [31:0]      perf_stall_cnt,
    output logic [31:0]      perf_yield_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        YIELD = 2'd2
    } state_t;

    // Last wait count before the core is owed a slot.
    localparam logic [7:0] WAIT_LAST = 8'(STARVE_LIMIT - 1);

    state_t             state;
    state_t             state_nxt;
    logic               lat_wr;
    logic [29:0]        lat_base;
    logic [LEN_W-1:0]   lat_len;
    logic [LEN_W-1:0]   beat_cnt;
    logic [7:0]         wait_cnt;
    logic               cmd_accept;
    logic               yield_now;
    logic               beat_fire;
    logic               last_fire;
    logic [31:0]        beat_addr;

    // Byte offset of the current beat; the add below wraps modulo 2^32.
    assign beat_addr = {lat_base, 2'b00} + 32'({beat_cnt, 2'b00});

    // Read data is shared by both requesters; it only matters to whoever owns the port.
    assign core_rdata = mem_rdata;
    assign ext_rdata  = mem_rdata;

    // Bits [1:0] of the base are dropped: bursts are always word aligned.
    logic unused_base_lsb;
    assign unused_base_lsb = ^ext_base[1:0];

    // Port mux, handshake and next-state decision.
    always_comb begin
        state_nxt      = state;
        core_stall     = 1'b0;
        ext_beat_ready = 1'b0;
        mem_wr         = core_req & core_wr;
        mem_addr       = core_addr;
        mem_wdata      = core_wdata;
        mem_mask       = core_mask;
        mem_load_ctrl  = core_load_ctrl;
        cmd_accept     = 1'b0;
        yield_now      = 1'b0;
        beat_fire      = 1'b0;
        last_fire      = 1'b0;
        case (state)
            IDLE: begin
                // A command arriving during the done pulse belongs to the finished burst window and is dropped.
                cmd_accept = ext_req & ~ext_done;
                if (cmd_accept) begin
                    state_nxt = BURST;
                end
            end
            BURST: begin
                mem_addr       = beat_addr;
                mem_mask       = 4'b1111;
                mem_load_ctrl  = 3'b010;
                mem_wdata      = ext_wdata;
                // Write strobe follows valid alone: in a yield cycle the same word is rewritten
                // with the same held data, which is harmless and keeps the strobe path short.
                mem_wr         = lat_wr & ext_beat_valid;
                core_stall     = core_req;
                yield_now      = core_req && (wait_cnt == WAIT_LAST);
                ext_beat_ready = ~yield_now;
                beat_fire      = ext_beat_valid & ext_beat_ready;
                last_fire      = beat_fire && (beat_cnt == lat_len);
                if (last_fire) begin
                    state_nxt = IDLE;
                end else if (yield_now) begin
                    state_nxt = YIELD;
                end
            end
            YIELD: begin
                state_nxt = BURST;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Burst command capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_wr   <= 1'b0;
            lat_base <= '0;
            lat_len  <= '0;
        end else if (cmd_accept) begin
            lat_wr   <= ext_wr;
            lat_base <= ext_base[31:2];
            lat_len  <= ext_len;
        end
    end

    // Beat counter: restarts on a new command, advances on each handshake, survives yields.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt <= '0;
        end else if (cmd_accept) begin
            beat_cnt <= '0;
        end else if (beat_fire) begin
            beat_cnt <= beat_cnt + 1'b1;
        end
    end

    // Starvation counter: consecutive BURST cycles with the core waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state == BURST && core_req) begin
            wait_cnt <= wait_cnt + 8'd1;
        end else begin
            wait_cnt <= '0;
        end
    end

    // Busy flag and one-cycle completion pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ext_busy <= 1'b0;
            ext_done <= 1'b0;
        end else begin
            ext_done <= last_fire;
            if (cmd_accept) begin
                ext_busy <= 1'b1;
            end else if (last_fire) begin
                ext_busy <= 1'b0;
            end
        end
    end

`ifdef ARB_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] yield_cnt_q;

    // Saturating counters of stalled core cycles and yield entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            yield_cnt_q <= '0;
        end else begin
            if (core_stall && stall_cnt_q != 32'hFFFF_FFFF) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (state == BURST && state_nxt == YIELD && yield_cnt_q != 32'hFFFF_FFFF) begin
                yield_cnt_q <= yield_cnt_q + 32'd1;
            end
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_yield_cnt = yield_cnt_q;
`else
    assign perf_stall_cnt = 32'd0;
    assign perf_yield_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: random core traffic and bursts against a word-memory scoreboard.
// Burst timing with a permanently waiting core is predicted in closed form from the starvation limit.
// Every wait on the DUT is bounded by a cycle budget.
module tb_dmem_arbiter;
    localparam int LEN_W = 8;
    localparam int LIMIT = 4;
    localparam int GROUP = LIMIT - 1;
    localparam int WORDS = 256;

    logic             clk;
    logic             rst;
    logic             core_req;
    logic             core_wr;
    logic [31:0]      core_addr;
    logic [31:0]      core_wdata;
    logic [3:0]       core_mask;
    logic [2:0]       core_load_ctrl;
    logic [31:0]      core_rdata;
    logic             core_stall;
    logic             ext_req;
    logic             ext_wr;
    logic [31:0]      ext_base;
    logic [LEN_W-1:0] ext_len;
    logic [31:0]      ext_wdata;
    logic             ext_beat_valid;
    logic             ext_beat_ready;
    logic [31:0]      ext_rdata;
    logic             ext_busy;
    logic             ext_done;
    logic             mem_wr;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic [3:0]       mem_mask;
    logic [2:0]       mem_load_ctrl;
    logic [31:0]      mem_rdata;
    logic [31:0]      perf_stall_cnt;
    logic [31:0]      perf_yield_cnt;

    dmem_arbiter #(.LEN_W(LEN_W), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_wr(core_wr), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_mask(core_mask), .core_load_ctrl(core_load_ctrl),
        .core_rdata(core_rdata), .core_stall(core_stall),
        .ext_req(ext_req), .ext_wr(ext_wr), .ext_base(ext_base), .ext_len(ext_len),
        .ext_wdata(ext_wdata), .ext_beat_valid(ext_beat_valid), .ext_beat_ready(ext_beat_ready),
        .ext_rdata(ext_rdata), .ext_busy(ext_busy), .ext_done(ext_done),
        .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_mask(mem_mask),
        .mem_load_ctrl(mem_load_ctrl), .mem_rdata(mem_rdata),
        .perf_stall_cnt(perf_stall_cnt), .perf_yield_cnt(perf_yield_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory seen by the DUT, and the scoreboard copy the bench predicts.
    logic [31:0] mem     [0:WORDS-1];
    logic [31:0] ref_mem [0:WORDS-1];
    logic        init_en;
    logic [7:0]  init_idx;
    logic [31:0] init_dat;

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w, input logic [3:0] m);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'(a[9:2]);
    endfunction

    function automatic logic [31:0] rand_addr();
        return {22'($urandom), 8'($urandom_range(0, WORDS - 1)), 2'b00};
    endfunction

    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (init_en) mem[init_idx] <= init_dat;
        else if (mem_wr) mem[mem_addr[9:2]] <= merge(mem[mem_addr[9:2]], mem_wdata, mem_mask);
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic core_op(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] mask, input logic [2:0] lc);
        core_req = 1'b1; core_wr = wr; core_addr = addr; core_wdata = data;
        core_mask = mask; core_load_ctrl = lc; ext_req = 1'b0; ext_beat_valid = 1'b0;
        #2;
        check("idle_mem_wr", mem_wr, wr);
        check("idle_mem_addr", mem_addr, addr);
        check("idle_mem_wdata", mem_wdata, data);
        check("idle_mem_mask", mem_mask, mask);
        check("idle_mem_lc", mem_load_ctrl, lc);
        check("idle_stall", core_stall, 1'b0);
        check("idle_ready", ext_beat_ready, 1'b0);
        if (wr) ref_mem[widx(addr)] = merge(ref_mem[widx(addr)], data, mask);
        else    check("idle_load", core_rdata, ref_mem[widx(addr)]);
        tick();
        core_req = 1'b0; core_wr = 1'b0;
    endtask

    task automatic mid_reset();
        core_req = 1'b1; core_wr = 1'b0; core_addr = rand_addr(); ext_beat_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("rst_busy", ext_busy, 1'b0);
        check("rst_ready", ext_beat_ready, 1'b0);
        check("rst_stall", core_stall, 1'b0);
        check("rst_done", ext_done, 1'b0);
        check("rst_addr", mem_addr, core_addr);
        tick();
        rst = 1'b0; core_req = 1'b0; ext_beat_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2;
            check("rst_no_done", ext_done, 1'b0);
            check("rst_idle_busy", ext_busy, 1'b0);
            tick();
        end
    endtask

    // mode 0: core idle, valid held; 1: core waiting every cycle, valid held; 2: random core/valid/ext_req.
    task automatic run_burst(input logic wr, input logic [31:0] base, input int len, input int mode,
                             input int rst_at, output int cycles);
        logic [31:0] data [$];
        logic [31:0] aligned;
        logic [31:0] exp_addr;
        int k, c, run, p;
        bit last;
        aligned = {base[31:2], 2'b00};
        for (int i = 0; i <= len; i++) data.push_back($urandom);
        ext_req = 1'b1; ext_wr = wr; ext_base = base; ext_len = LEN_W'(len); ext_beat_valid = 1'b0;
        core_req = (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        core_wr = 1'b0; core_addr = rand_addr(); core_mask = 4'hF; core_load_ctrl = 3'b010;
        #2;
        check("cmd_stall", core_stall, 1'b0);
        check("cmd_ready", ext_beat_ready, 1'b0);
        check("cmd_addr", mem_addr, core_addr);
        if (core_req) check("cmd_load", core_rdata, ref_mem[widx(core_addr)]);
        tick();
        k = 0; c = 0; run = 0; last = 1'b0;
        while (!last && c < 4000) begin
            if (rst_at >= 0 && k == rst_at) begin
                mid_reset();
                cycles = c;
                return;
            end
            ext_req        = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            core_req       = (mode == 1) ? 1'b1 : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            core_addr      = rand_addr();
            ext_beat_valid = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
            ext_wdata      = data[k];
            #2;
            check("busy", ext_busy, 1'b1);
            check("done_low", ext_done, 1'b0);
            if (ext_beat_ready) check("stall_eq_req", core_stall, core_req);
            if (core_req && !core_stall) begin
                check("yield_addr", mem_addr, core_addr);
                check("yield_load", core_rdata, ref_mem[widx(core_addr)]);
                check("yield_ready", ext_beat_ready, 1'b0);
            end
            run = core_stall ? run + 1 : 0;
            check("starve_bound", (run <= LIMIT), 1'b1);
            if (mode == 1) begin
                p = c % (LIMIT + 1);
                check("pat_ready", ext_beat_ready, (p < GROUP));
                check("pat_stall", core_stall, (p != LIMIT));
            end
            if (ext_beat_valid && ext_beat_ready) begin
                exp_addr = aligned + 32'(4 * k);
                check("beat_addr", mem_addr, exp_addr);
                check("beat_wr", mem_wr, wr);
                check("beat_mask", mem_mask, 4'hF);
                if (wr) begin
                    check("beat_wdata", mem_wdata, data[k]);
                    ref_mem[widx(exp_addr)] = data[k];
                end else begin
                    check("beat_rdata", ext_rdata, ref_mem[widx(exp_addr)]);
                end
                k++;
                last = (k == len + 1);
            end
            tick();
            c++;
        end
        cycles = c;
        check("burst_finished", last, 1'b1);
        // Done cycle, carrying a stray command that must be dropped.
        ext_req = 1'b1; ext_beat_valid = 1'b0; core_req = 1'b0;
        #2;
        check("done_pulse", ext_done, 1'b1);
        check("done_busy", ext_busy, 1'b0);
        check("done_ready", ext_beat_ready, 1'b0);
        tick();
        ext_req = 1'b0;
        #2;
        check("done_once", ext_done, 1'b0);
        check("post_busy", ext_busy, 1'b0);
        check("post_ready", ext_beat_ready, 1'b0);
        tick();
    endtask

    int cyc, n_beats, exp_yields, nmis;

    initial begin
        rst = 1'b1; init_en = 1'b0; init_idx = '0; init_dat = '0;
        core_req = 1'b0; core_wr = 1'b0; core_addr = '0; core_wdata = '0;
        core_mask = '0; core_load_ctrl = '0;
        ext_req = 1'b0; ext_wr = 1'b0; ext_base = '0; ext_len = '0; ext_wdata = '0; ext_beat_valid = 1'b0;
        tick();
        for (int i = 0; i < WORDS; i++) begin
            init_en = 1'b1; init_idx = 8'(i); init_dat = $urandom; ref_mem[i] = init_dat;
            tick();
        end
        init_en = 1'b0;

        // Reset state: IDLE mux, no stall, no handshake, counters clear.
        core_req = 1'b1; core_addr = 32'h0000_1234; core_mask = 4'h3; core_load_ctrl = 3'b100;
        #2;
        check("reset_stall", core_stall, 1'b0);
        check("reset_ready", ext_beat_ready, 1'b0);
        check("reset_busy", ext_busy, 1'b0);
        check("reset_done", ext_done, 1'b0);
        check("reset_addr", mem_addr, 32'h0000_1234);
        check("reset_mask", mem_mask, 4'h3);
        check("reset_lc", mem_load_ctrl, 3'b100);
        check("reset_perf_stall", perf_stall_cnt, 32'd0);
        check("reset_perf_yield", perf_yield_cnt, 32'd0);
        tick();
        rst = 1'b0; core_req = 1'b0;

        core_op(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 3'b010);
        core_op(1'b0, 32'h0000_0010, 32'h0, 4'hF, 3'b010);
        for (int i = 0; i < 16; i++)
            core_op(1'($urandom_range(0, 1)), rand_addr(), $urandom, 4'($urandom), 3'($urandom));

        run_burst(1'b1, 32'h0000_0100, 3, 0, -1, cyc);
        check("wr_burst_cycles", cyc, 32'd4);

        run_burst(1'b1, 32'hFFFF_FFFC, 1, 0, -1, cyc);
        core_op(1'b0, 32'hFFFF_FFFC, 32'h0, 4'hF, 3'b010);
        core_op(1'b0, 32'h0000_0000, 32'h0, 4'hF, 3'b010);

        run_burst(1'b1, rand_addr(), (1 << LEN_W) - 1, 0, -1, cyc);
        check("max_len_cycles", cyc, 32'(1 << LEN_W));

        for (int i = 0; i < 12; i++)
            run_burst(1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 20), 2, -1, cyc);

        run_burst(1'b1, rand_addr(), 7, 1, 2, cyc);
        #2;
        check("perf_stall_cleared", perf_stall_cnt, 32'd0);
        check("perf_yield_cleared", perf_yield_cnt, 32'd0);
        tick();

        // Read burst with the core waiting throughout: groups of GROUP beats, each followed by
        // one refused cycle and one core slot.
        run_burst(1'b0, 32'h0000_0200, 9, 1, -1, cyc);
        n_beats    = 10;
        exp_yields = (n_beats - 1) / GROUP;
        check("starve_burst_cycles", cyc, 32'(n_beats + 2 * exp_yields));
        #2;
`ifdef ARB_PERF_EN
        check("perf_yield", perf_yield_cnt, 32'(exp_yields));
        check("perf_stall", perf_stall_cnt, 32'(n_beats + exp_yields));
`else
        check("perf_yield_tied", perf_yield_cnt, 32'd0);
        check("perf_stall_tied", perf_stall_cnt, 32'd0);
`endif
        tick();

        nmis = 0;
        for (int i = 0; i < WORDS; i++) if (mem[i] !== ref_mem[i]) nmis++;
        check("mem_image_mismatches", nmis, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
